snake_progress_tracker: RTL and testbench

//  Game-progress stage that drives the green-LED bar driver. Consumes game events
//  (apple eaten, crash, start, pause) and runs a game-state FSM. Produces:
//  - oOUTGO: bar position 0..19.
//  - oHAND: pause/over flag.
//  - level, score, and a level-dependent snake-move tick oSTEP for the VGA game logic.

---
 rtl/snake_pkg.sv | 27 ++
 rtl/step_tick_gen.sv | 35 +++
 rtl/snake_progress_tracker.sv | 161 ++++++++++++++++
 tb/tb_snake_progress_tracker.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared types and constants for the snake game-progress tracker.
// Includes the level-dependent move-period calculation.
package snake_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StPlay  = 2'd1,
    StPause = 2'd2,
    StOver  = 2'd3
  } state_e;

  localparam int unsigned PROGRESS_MAX = 19;
  localparam int unsigned SCORE_MAX    = 255;

  // Clamp at min_p before subtracting so the result can never wrap below it.
  function automatic logic [27:0] step_period(input logic [27:0] base,
                                              input logic [27:0] dec_per_lvl,
                                              input logic [27:0] min_p,
                                              input logic [3:0]  level);
    logic [27:0] dec;
    dec = dec_per_lvl * {24'd0, level};
    if (base <= min_p) return min_p;
    if (dec >= base - min_p) return min_p;
    return base - dec;
  endfunction

endpackage

// File: rtl/step_tick_gen.sv
// Period counter producing a registered one-clock tick every iPERIOD enabled clocks.
// Holding iEN low freezes the count; iCLR restarts it from zero.
module step_tick_gen (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iEN,
  input  logic        iCLR,
  input  logic [27:0] iPERIOD,
  output logic        oTICK
);

  logic [27:0] cnt_q;
  logic        tick_q;

  always_ff @(posedge iCLK) begin
    if (iRST || iCLR) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else if (iEN) begin
      // >= so a shortened period takes effect at once even past the new end point.
      if (cnt_q >= iPERIOD - 28'd1) begin
        cnt_q  <= '0;
        tick_q <= 1'b1;
      end else begin
        cnt_q  <= cnt_q + 28'd1;
        tick_q <= 1'b0;
      end
    end else begin
      tick_q <= 1'b0;
    end
  end

  assign oTICK = tick_q;

endmodule

// File: rtl/snake_progress_tracker.sv
// Game-progress stage: game-state FSM, LED bar position, level, score and move tick.
// Events are rising edges of level inputs; all outputs are registered.
module snake_progress_tracker
  import snake_pkg::*;
#(
  parameter int unsigned BASE_PERIOD = 12_500_000,
  parameter int unsigned PERIOD_STEP = 1_000_000,
  parameter int unsigned MIN_PERIOD  = 2_500_000,
  parameter int unsigned MAX_LEVEL   = 9,
  parameter int unsigned ATTRACT_DIV = 5_000_000,
  parameter int unsigned OVER_HOLD   = 250_000_000
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic       iEAT,
  input  logic       iCRASH,
  input  logic       iSTART,
  input  logic       iPAUSE,
  output logic [4:0] oOUTGO,
  output logic       oHAND,
  output logic [3:0] oLEVEL,
  output logic [7:0] oSCORE,
  output logic       oSTEP
);

  localparam logic [4:0]  PosMax   = 5'(PROGRESS_MAX);
  localparam logic [7:0]  ScoreMax = 8'(SCORE_MAX);
  localparam logic [3:0]  LvlMax   = 4'(MAX_LEVEL);
  localparam logic [27:0] AttLast  = 28'(ATTRACT_DIV - 1);
  localparam logic [27:0] HoldLast = 28'(OVER_HOLD - 1);

  state_e      state_q;
  logic        eat_q, crash_q, start_q, pause_q;
  logic [4:0]  outgo_q;
  logic [3:0]  level_q;
  logic [7:0]  score_q;
  logic        hand_q;
  logic        sweep_up_q;
  logic [27:0] att_q;
  logic [27:0] hold_q;

  logic        eat_rise, crash_rise, start_rise, pause_rise;
  logic        new_game, step_en, step_tick;
  logic [27:0] period;

  assign eat_rise   = iEAT & ~eat_q;
  assign crash_rise = iCRASH & ~crash_q;
  assign start_rise = iSTART & ~start_q;
  assign pause_rise = iPAUSE & ~pause_q;

  assign new_game = start_rise & ((state_q == StIdle) | (state_q == StOver));
  // Only count clocks that stay in PLAY, so no tick escapes into PAUSE or OVER.
  assign step_en  = (state_q == StPlay) & ~crash_rise & ~pause_rise;
  assign period   = step_period(28'(BASE_PERIOD), 28'(PERIOD_STEP), 28'(MIN_PERIOD), level_q);

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q    <= StIdle;
      eat_q      <= 1'b0;
      crash_q    <= 1'b0;
      start_q    <= 1'b0;
      pause_q    <= 1'b0;
      outgo_q    <= '0;
      level_q    <= '0;
      score_q    <= '0;
      hand_q     <= 1'b0;
      sweep_up_q <= 1'b1;
      att_q      <= '0;
      hold_q     <= '0;
    end else begin
      eat_q   <= iEAT;
      crash_q <= iCRASH;
      start_q <= iSTART;
      pause_q <= iPAUSE;
      if (new_game) begin
        state_q <= StPlay;
        outgo_q <= '0;
        level_q <= '0;
        score_q <= '0;
        hand_q  <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (att_q == AttLast) begin
              att_q <= '0;
              if (sweep_up_q) begin
                if (outgo_q == PosMax) begin
                  outgo_q    <= PosMax - 5'd1;
                  sweep_up_q <= 1'b0;
                end else begin
                  outgo_q <= outgo_q + 5'd1;
                end
              end else if (outgo_q == 5'd0) begin
                outgo_q    <= 5'd1;
                sweep_up_q <= 1'b1;
              end else begin
                outgo_q <= outgo_q - 5'd1;
              end
            end else begin
              att_q <= att_q + 28'd1;
            end
          end
          StPlay: begin
            if (crash_rise) begin
              state_q <= StOver;
              hand_q  <= 1'b1;
              hold_q  <= '0;
            end else begin
              if (eat_rise) begin
                if (score_q != ScoreMax) score_q <= score_q + 8'd1;
                if (outgo_q == PosMax) begin
                  outgo_q <= '0;
                  if (level_q != LvlMax) level_q <= level_q + 4'd1;
                end else begin
                  outgo_q <= outgo_q + 5'd1;
                end
              end
              if (pause_rise) begin
                state_q <= StPause;
                hand_q  <= 1'b1;
              end
            end
          end
          StPause: begin
            if (pause_rise) begin
              state_q <= StPlay;
              hand_q  <= 1'b0;
            end
          end
          StOver: begin
            if (hold_q == HoldLast) begin
              state_q    <= StIdle;
              hand_q     <= 1'b0;
              att_q      <= '0;
              sweep_up_q <= 1'b1;
            end else begin
              hold_q <= hold_q + 28'd1;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  step_tick_gen u_step_tick_gen (
    .iCLK   (iCLK),
    .iRST   (iRST),
    .iEN    (step_en),
    .iCLR   (new_game),
    .iPERIOD(period),
    .oTICK  (step_tick)
  );

  assign oOUTGO = outgo_q;
  assign oHAND  = hand_q;
  assign oLEVEL = level_q;
  assign oSCORE = score_q;
  assign oSTEP  = step_tick;

endmodule

// File: tb/tb_snake_progress_tracker.sv
// Directed and randomized bench for snake_progress_tracker against a game-rule model.
module tb_snake_progress_tracker;

  localparam int BASE  = 20;
  localparam int PSTEP = 2;
  localparam int MINP  = 6;
  localparam int MAXL  = 9;
  localparam int ATT   = 3;
  localparam int HOLD  = 50;

  localparam int MIdle  = 0;
  localparam int MPlay  = 1;
  localparam int MPause = 2;
  localparam int MOver  = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       eat = 1'b0, crash = 1'b0, start = 1'b0, pause = 1'b0;
  logic [4:0] outgo;
  logic       hand;
  logic [3:0] level;
  logic [7:0] score;
  logic       stp;

  int checks = 0;
  int errors = 0;

  // Model of the game, expressed in game terms.
  int m_st, m_pos, m_lvl, m_score, m_k, m_att, m_hold, m_cnt;
  bit m_step;
  bit p_eat, p_crash, p_start, p_pause;

  snake_progress_tracker #(
    .BASE_PERIOD(BASE),
    .PERIOD_STEP(PSTEP),
    .MIN_PERIOD (MINP),
    .MAX_LEVEL  (MAXL),
    .ATTRACT_DIV(ATT),
    .OVER_HOLD  (HOLD)
  ) dut (
    .iCLK  (clk),
    .iRST  (rst),
    .iEAT  (eat),
    .iCRASH(crash),
    .iSTART(start),
    .iPAUSE(pause),
    .oOUTGO(outgo),
    .oHAND (hand),
    .oLEVEL(level),
    .oSCORE(score),
    .oSTEP (stp)
  );

  always #5 clk = ~clk;

  // Attract sweep as a triangle wave over sweep index k: 0..19..1, period 38.
  function automatic int tri_pos(input int k);
    int r;
    r = k % 38;
    return (r <= 19) ? r : 38 - r;
  endfunction

  function automatic int period_of(input int lvl);
    int p;
    p = BASE - lvl * PSTEP;
    return (p < MINP) ? MINP : p;
  endfunction

  task automatic model_fresh();
    m_st = MPlay; m_pos = 0; m_lvl = 0; m_score = 0; m_cnt = 0;
  endtask

  task automatic model_clock(input bit r, input bit e, input bit c, input bit s, input bit p);
    bit er, cr, sr, pr;
    if (r) begin
      m_st = MIdle; m_pos = 0; m_lvl = 0; m_score = 0; m_k = 0; m_att = 0;
      m_hold = 0; m_cnt = 0; m_step = 0;
      p_eat = 0; p_crash = 0; p_start = 0; p_pause = 0;
      return;
    end
    er = e & ~p_eat; cr = c & ~p_crash; sr = s & ~p_start; pr = p & ~p_pause;
    p_eat = e; p_crash = c; p_start = s; p_pause = p;
    m_step = 0;
    case (m_st)
      MIdle: begin
        if (sr) model_fresh();
        else begin
          m_att++;
          if (m_att == ATT) begin
            m_att = 0;
            m_k = (m_k + 1) % 38;
            m_pos = tri_pos(m_k);
          end
        end
      end
      MPlay: begin
        if (!cr && !pr) begin
          if (m_cnt >= period_of(m_lvl) - 1) begin m_cnt = 0; m_step = 1; end
          else m_cnt++;
        end
        if (cr) begin
          m_st = MOver; m_hold = 0;
        end else begin
          if (er) begin
            if (m_score < 255) m_score++;
            if (m_pos < 19) m_pos++;
            else begin
              m_pos = 0;
              if (m_lvl < MAXL) m_lvl++;
            end
          end
          if (pr) m_st = MPause;
        end
      end
      MPause: if (pr) m_st = MPlay;
      default: begin
        if (sr) model_fresh();
        else begin
          m_hold++;
          if (m_hold == HOLD) begin
            m_st = MIdle; m_att = 0; m_k = m_pos;
          end
        end
      end
    endcase
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input bit r, input bit e, input bit c, input bit s, input bit p);
    @(negedge clk);
    rst = r; eat = e; crash = c; start = s; pause = p;
    @(posedge clk);
    model_clock(r, e, c, s, p);
    #1;
    chk("outgo", 32'(outgo), m_pos);
    chk("hand",  32'(hand),  (m_st == MPause || m_st == MOver) ? 1 : 0);
    chk("level", 32'(level), m_lvl);
    chk("score", 32'(score), m_score);
    chk("step",  32'(stp),   32'(m_step));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
  endtask

  task automatic pulse_eat();
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
  endtask

  task automatic pulse_pause();
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0);
  endtask

  task automatic pulse_start();
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0);
  endtask

  // Clocks until the next oSTEP pulse; a missing pulse within 100 clocks is a failure.
  task automatic wait_step(output int n);
    n = 0;
    do begin
      cyc(0, 0, 0, 0, 0);
      n++;
    end while (stp !== 1'b1 && n < 100);
    chk("step_timeout", 32'(n < 100), 1);
  endtask

  initial begin
    int n, pulses, pre;
    bit re, rc, rs, rp;

    // Reset and attract sweep.
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    chk("rst_outgo", 32'(outgo), 0);
    chk("rst_hand", 32'(hand), 0);
    chk("rst_step", 32'(stp), 0);
    idle(12);
    cyc(0, 0, 0, 1, 0);
    chk("start_outgo", 32'(outgo), 0);
    chk("start_hand", 32'(hand), 0);
    cyc(0, 0, 0, 0, 0);

    // Move period at level 0.
    wait_step(n);
    wait_step(n);
    chk("period_lvl0", n, 20);

    // 21 eats: wrap once into level 1; a long eat counts once.
    for (int i = 0; i < 21; i++) pulse_eat();
    chk("eat21_outgo", 32'(outgo), 1);
    chk("eat21_level", 32'(level), 1);
    chk("eat21_score", 32'(score), 21);
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("held_eat_score", 32'(score), 22);

    // Level 7 clamps the period to MIN_PERIOD.
    for (int g = 0; g < 400 && m_lvl < 7; g++) pulse_eat();
    chk("lvl7", 32'(level), 7);
    wait_step(n);
    wait_step(n);
    chk("period_lvl7", n, 6);

    // Pause freezes the step counter.
    pulse_pause();
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      cyc(0, 0, 0, 0, 0);
      if (stp === 1'b1) pulses++;
    end
    chk("pause_no_step", pulses, 0);
    chk("pause_hand", 32'(hand), 1);
    pulse_pause();
    idle(15);

    // Crash beats a same-cycle eat; OVER returns to IDLE after HOLD clocks.
    pre = m_score;
    cyc(0, 1, 1, 0, 0);
    chk("crash_score", 32'(score), pre);
    chk("crash_hand", 32'(hand), 1);
    idle(49);
    chk("over_hold", 32'(hand), 1);
    idle(1);
    chk("over_exit", 32'(hand), 0);
    idle(10);

    // Eat with pause counts first; eat in PAUSE ignored; score and level saturate.
    pulse_start();
    cyc(0, 1, 0, 0, 1);
    chk("eat_pause_score", 32'(score), 1);
    chk("eat_pause_hand", 32'(hand), 1);
    cyc(0, 0, 0, 0, 0);
    pulse_eat();
    chk("pause_eat_ignored", 32'(score), 1);
    pulse_pause();
    for (int i = 0; i < 300; i++) pulse_eat();
    chk("sat_score", 32'(score), 255);
    chk("sat_level", 32'(level), 9);

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      re = ($urandom_range(0, 3) == 0);
      rc = ($urandom_range(0, 63) == 0);
      rs = ($urandom_range(0, 31) == 0);
      rp = ($urandom_range(0, 31) == 0);
      cyc(0, re, rc, rs, rp);
    end

    // Reset mid-game with the bar at 7.
    cyc(1, 0, 0, 0, 0);
    idle(2);
    pulse_start();
    for (int i = 0; i < 7; i++) pulse_eat();
    chk("mid_outgo", 32'(outgo), 7);
    cyc(1, 0, 0, 0, 0);
    chk("mid_rst_outgo", 32'(outgo), 0);
    chk("mid_rst_score", 32'(score), 0);
    chk("mid_rst_level", 32'(level), 0);
    chk("mid_rst_hand", 32'(hand), 0);
    chk("mid_rst_step", 32'(stp), 0);
    idle(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
